// File: rtl/voice_allocator.sv
// voice_allocator
// Polyphonic voice scheduler for the NCO bank. Each accepted note event is
// scanned against every voice, one voice per cycle. The result is then applied
// in a single commit cycle. For a note-on, the target is chosen in this order:
// a voice already gated on the same note (retrigger), then the lowest free
// voice, then the oldest voice (steal). A note-off releases the lowest gated
// voice that holds the same note.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   ev_valid     note event offered by the MIDI decoder
//   ev_ready     event accepted when high together with ev_valid (IDLE only)
//   ev_on        1 = note-on, 0 = note-off
//   ev_note      MIDI note number, sampled only on accept
//   panic        synchronous all-notes-off; drops any in-flight event
//   voice_note   packed note number per voice, voice i at [7i+6:7i]
//   voice_gate   gate per voice
//   voice_trig   one-cycle pulse on the voice just (re)assigned
module voice_allocator #(
    parameter int VOICES = 4,
    parameter int VW     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ev_valid,
    output logic                ev_ready,
    input  logic                ev_on,
    input  logic [6:0]          ev_note,
    input  logic                panic,
    output logic [VOICES*7-1:0] voice_note,
    output logic [VOICES-1:0]   voice_gate,
    output logic [VOICES-1:0]   voice_trig
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [VW-1:0] LAST = VW'(VOICES - 1);

    state_t                   state_q, state_d;
    logic [VW-1:0]            idx_q, idx_d;
    logic                     ev_on_q, ev_on_d;
    logic [6:0]               ev_note_q, ev_note_d;
    logic                     match_found_q, match_found_d;
    logic [VW-1:0]            match_idx_q, match_idx_d;
    logic                     free_found_q, free_found_d;
    logic [VW-1:0]            free_idx_q, free_idx_d;
    logic [VW-1:0]            oldest_idx_q, oldest_idx_d;
    logic [VOICES*7-1:0]      note_q, note_d;
    logic [VOICES-1:0]        gate_q, gate_d;
    logic [VOICES-1:0]        trig_q, trig_d;
    // Age rank per voice: 0 is the most recently assigned voice.
    logic [VOICES-1:0][VW-1:0] rank_q, rank_d;
    logic [VW-1:0]            target;
    logic [VW-1:0]            target_rank;

    assign ev_ready   = (state_q == IDLE);
    assign voice_note = note_q;
    assign voice_gate = gate_q;
    assign voice_trig = trig_q;

    // Next-state logic. The scan records the lowest-index hits only, because a
    // found flag blocks any later voice from overwriting the recorded index.
    // Panic is evaluated last so that it overrides any event in progress.
    // Note numbers and ranks keep their current values under panic.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ev_on_d       = ev_on_q;
        ev_note_d     = ev_note_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        oldest_idx_d  = oldest_idx_q;
        note_d        = note_q;
        gate_d        = gate_q;
        trig_d        = '0;
        rank_d        = rank_q;
        target        = '0;
        target_rank   = '0;

        case (state_q)
            IDLE: begin
                if (ev_valid) begin
                    ev_on_d       = ev_on;
                    ev_note_d     = ev_note;
                    idx_d         = '0;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
                    oldest_idx_d  = '0;
                    state_d       = SCAN;
                end
            end
            SCAN: begin
                for (int i = 0; i < VOICES; i++) begin
                    if (VW'(i) == idx_q) begin
                        if (gate_q[i] && (note_q[7*i +: 7] == ev_note_q) && !match_found_q) begin
                            match_found_d = 1'b1;
                            match_idx_d   = VW'(i);
                        end
                        if (!gate_q[i] && !free_found_q) begin
                            free_found_d = 1'b1;
                            free_idx_d   = VW'(i);
                        end
                        if (rank_q[i] == LAST) begin
                            oldest_idx_d = VW'(i);
                        end
                    end
                end
                if (idx_q == LAST) begin
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q + VW'(1);
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (ev_on_q) begin
                    if (match_found_q) begin
                        target = match_idx_q;
                    end else if (free_found_q) begin
                        target = free_idx_q;
                    end else begin
                        target = oldest_idx_q;
                    end
                    for (int i = 0; i < VOICES; i++) begin
                        if (VW'(i) == target) begin
                            target_rank = rank_q[i];
                        end
                    end
                    // Voices younger than the target age by one step, so the
                    // ranks stay a permutation and the target becomes newest.
                    for (int i = 0; i < VOICES; i++) begin
                        if (VW'(i) == target) begin
                            note_d[7*i +: 7] = ev_note_q;
                            gate_d[i]        = 1'b1;
                            trig_d[i]        = 1'b1;
                            rank_d[i]        = '0;
                        end else if (rank_q[i] < target_rank) begin
                            rank_d[i] = rank_q[i] + VW'(1);
                        end
                    end
                end else if (match_found_q) begin
                    for (int i = 0; i < VOICES; i++) begin
                        if (VW'(i) == match_idx_q) begin
                            gate_d[i] = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (panic) begin
            state_d = IDLE;
            gate_d  = '0;
            trig_d  = '0;
            note_d  = note_q;
            rank_d  = rank_q;
        end
    end

    // State and voice registers. The ranks reset to voice order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            ev_on_q       <= 1'b0;
            ev_note_q     <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            oldest_idx_q  <= '0;
            note_q        <= '0;
            gate_q        <= '0;
            trig_q        <= '0;
            for (int i = 0; i < VOICES; i++) begin
                rank_q[i] <= VW'(i);
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            ev_on_q       <= ev_on_d;
            ev_note_q     <= ev_note_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            oldest_idx_q  <= oldest_idx_d;
            note_q        <= note_d;
            gate_q        <= gate_d;
            trig_q        <= trig_d;
            rank_q        <= rank_d;
        end
    end

endmodule
